wb_flush_ctrl: RTL and testbench

Redirect and flush controller that sits beside the WB stage. It merges the three WB redirect sources (exception, ertn, refetch) into one prioritized flush pulse and a held redirect request to IF. It also tracks outstanding instruction-SRAM requests, so fetch responses that were already in flight when a flush happened are discarded rather than delivered to ID.

---
 rtl/cpu_defs_pkg.sv | 29 ++
 rtl/wb_flush_ctrl_inflight_counter.sv | 48 ++++
 rtl/wb_flush_ctrl.sv | 118 +++++++++++
 tb/tb_wb_flush_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: redirect FSM encoding, CSR numbers, ecodes and
// the flush-target selection helper used by the WB redirect logic.
package cpu_defs;

    // Redirect FSM states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_REDIR = 1'b1
    } redir_state_e;

    // CSR numbers whose values can be presented on csr_entry
    localparam logic [13:0] CSR_EENTRY    = 14'h0c;
    localparam logic [13:0] CSR_TLBRENTRY = 14'h88;
    localparam logic [13:0] CSR_ERA       = 14'h06;

    // Exception code for TLB refill
    localparam logic [5:0]  ECODE_TLBR    = 6'h3f;

    // Exception and ertn both jump to the CSR-provided address; a bare
    // refetch restarts at the instruction after the WB one (wraps mod 2^32).
    function automatic logic [31:0] flush_target(
        input logic        ex_or_ertn,
        input logic [31:0] csr_entry,
        input logic [31:0] wb_pc
    );
        return ex_or_ertn ? csr_entry : (wb_pc + 32'd4);
    endfunction

endpackage

// File: rtl/wb_flush_ctrl_inflight_counter.sv
// Up/down saturating in-flight counter. Flags an error (one cycle, combinational)
// when an increment would exceed MAX_COUNT or a decrement hits an empty counter.
module inflight_counter #(
    parameter int unsigned MAX_COUNT = 2,
    parameter int unsigned W         = $clog2(MAX_COUNT + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt,
    output logic         err
);

    localparam logic [W-1:0] MAX_W = W'(MAX_COUNT);

    // Next count with saturation at both ends plus error detection
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        count_nxt = count;
        err       = 1'b0;
        if (dec && count == '0) begin
            // A response with nothing in flight is a protocol violation even
            // if a new request fires in the same cycle; the count stays put.
            err = 1'b1;
        end else if (inc && !dec) begin
            if (count == MAX_W) begin
                err = 1'b1;
            end else begin
                count_nxt = count + W'(1);
            end
        end else if (dec && !inc) begin
            count_nxt = count - W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/wb_flush_ctrl.sv
// WB-side redirect and flush controller. Merges exception/ertn/refetch into a
// single flush pulse, holds the redirect target for IF until accepted, and
// tracks in-flight fetches so responses from flushed fetches are dropped.
module wb_flush_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_ex,
    input  logic             ertn_flush,
    input  logic             wb_refetch_flush,
    input  logic [31:0]      csr_entry,
    input  logic [31:0]      wb_pc,
    input  logic             fs_req_fire,
    input  logic             fs_resp,
    input  logic             fs_redirect_ready,
    output logic             pipe_flush,
    output logic             fs_redirect_valid,
    output logic [31:0]      fs_redirect_pc,
    output logic             fs_req_block,
    output logic             fs_resp_discard,
    output logic [CNT_W-1:0] outstanding,
    output logic             proto_err
);

    redir_state_e     state;
    redir_state_e     state_nxt;
    logic [31:0]      redir_pc;
    logic [31:0]      flush_pc;
    logic             flush_evt;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] discard_cnt;
    logic             cnt_err;

    assign flush_evt  = wb_ex | ertn_flush | wb_refetch_flush;
    assign pipe_flush = flush_evt;
    assign flush_pc   = flush_target(wb_ex | ertn_flush, csr_entry, wb_pc);

    inflight_counter #(
        .MAX_COUNT (MAX_OUTSTANDING),
        .W         (CNT_W)
    ) u_outstanding (
        .clk       (clk),
        .reset     (reset),
        .inc       (fs_req_fire),
        .dec       (fs_resp),
        .count     (outstanding),
        .count_nxt (outstanding_nxt),
        .err       (cnt_err)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: any flush (re)enters REDIR; acceptance without a new flush returns to IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (flush_evt) state_nxt = ST_REDIR;
            ST_REDIR: if (flush_evt) state_nxt = ST_REDIR;
                      else if (fs_redirect_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Redirect target: the newest flush always overwrites the pending target
    always_ff @(posedge clk) begin
        if (reset) begin
            redir_pc <= 32'd0;
        end else if (flush_evt) begin
            redir_pc <= flush_pc;
        end
    end

    // Discard counter: on flush, every fetch still in flight after this cycle must be dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= '0;
        end else if (flush_evt) begin
            discard_cnt <= outstanding_nxt;
        end else if (fs_resp && discard_cnt != '0) begin
            discard_cnt <= discard_cnt - CNT_W'(1);
        end
    end

    // Sticky protocol-error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (cnt_err) begin
            proto_err <= 1'b1;
        end
    end

    // Outputs to IF, forced quiet while reset is asserted
    always_comb begin
        fs_redirect_valid = 1'b0;
        fs_redirect_pc    = 32'd0;
        fs_req_block      = 1'b0;
        fs_resp_discard   = 1'b0;
        if (!reset) begin
            fs_redirect_valid = (state == ST_REDIR);
            fs_redirect_pc    = redir_pc;
            fs_req_block      = (state == ST_REDIR) | flush_evt;
            fs_resp_discard   = fs_resp & (discard_cnt != '0);
        end
    end

endmodule

// File: tb/tb_wb_flush_ctrl.sv
// Directed self-checking bench for wb_flush_ctrl.
module tb_wb_flush_ctrl;

    logic        clk;
    logic        reset;
    logic        wb_ex;
    logic        ertn_flush;
    logic        wb_refetch_flush;
    logic [31:0] csr_entry;
    logic [31:0] wb_pc;
    logic        fs_req_fire;
    logic        fs_resp;
    logic        fs_redirect_ready;
    logic        pipe_flush;
    logic        fs_redirect_valid;
    logic [31:0] fs_redirect_pc;
    logic        fs_req_block;
    logic        fs_resp_discard;
    logic [1:0]  outstanding;
    logic        proto_err;

    int passes = 0;
    int total  = 0;

    wb_flush_ctrl #(.MAX_OUTSTANDING(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .wb_ex             (wb_ex),
        .ertn_flush        (ertn_flush),
        .wb_refetch_flush  (wb_refetch_flush),
        .csr_entry         (csr_entry),
        .wb_pc             (wb_pc),
        .fs_req_fire       (fs_req_fire),
        .fs_resp           (fs_resp),
        .fs_redirect_ready (fs_redirect_ready),
        .pipe_flush        (pipe_flush),
        .fs_redirect_valid (fs_redirect_valid),
        .fs_redirect_pc    (fs_redirect_pc),
        .fs_req_block      (fs_req_block),
        .fs_resp_discard   (fs_resp_discard),
        .outstanding       (outstanding),
        .proto_err         (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passes++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    // Advance past the next rising edge; inputs are then changed mid-cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_ex = 0; ertn_flush = 0; wb_refetch_flush = 0;
        fs_req_fire = 0; fs_resp = 0; fs_redirect_ready = 0;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1; csr_entry = 0; wb_pc = 0;
        idle_inputs();
        tick(); tick();
        settle();
        check("rst_valid", {31'd0, fs_redirect_valid}, 0);
        check("rst_pc", fs_redirect_pc, 0);
        reset = 0;
        settle();
        check("rst_block", {31'd0, fs_req_block}, 0);
        check("rst_discard", {31'd0, fs_resp_discard}, 0);
        check("rst_outstanding", {30'd0, outstanding}, 0);
        check("rst_proto_err", {31'd0, proto_err}, 0);
        check("rst_pipe_flush", {31'd0, pipe_flush}, 0);

        // Exception with 1-cycle redirect occupancy
        wb_ex = 1; csr_entry = 32'h1C008000;
        settle();
        check("ex_pipe_flush", {31'd0, pipe_flush}, 1);
        check("ex_block_t", {31'd0, fs_req_block}, 1);
        check("ex_valid_t", {31'd0, fs_redirect_valid}, 0);
        tick();
        idle_inputs(); fs_redirect_ready = 1;
        settle();
        check("ex_valid_t1", {31'd0, fs_redirect_valid}, 1);
        check("ex_pc_t1", fs_redirect_pc, 32'h1C008000);
        check("ex_pipe_flush_t1", {31'd0, pipe_flush}, 0);
        tick();
        idle_inputs();
        settle();
        check("ex_valid_t2", {31'd0, fs_redirect_valid}, 0);
        check("ex_block_t2", {31'd0, fs_req_block}, 0);

        // Refetch with ready held low for 3 cycles
        wb_refetch_flush = 1; wb_pc = 32'h1C000100;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) fs_redirect_ready = 1;
            settle();
            check($sformatf("rf_valid_%0d", i), {31'd0, fs_redirect_valid}, 1);
            check($sformatf("rf_pc_%0d", i), fs_redirect_pc, 32'h1C000104);
            check($sformatf("rf_block_%0d", i), {31'd0, fs_req_block}, 1);
            tick();
        end
        idle_inputs();
        settle();
        check("rf_valid_done", {31'd0, fs_redirect_valid}, 0);

        // Priority: exception beats refetch
        wb_ex = 1; wb_refetch_flush = 1; csr_entry = 32'h1C010000; wb_pc = 32'h1C000000;
        tick();
        idle_inputs();
        settle();
        check("prio_ex_pc", fs_redirect_pc, 32'h1C010000);
        // Newer flush during REDIR (ertn beats refetch) wins even with ready high
        ertn_flush = 1; wb_refetch_flush = 1; csr_entry = 32'h1C020000; fs_redirect_ready = 1;
        tick();
        idle_inputs();
        settle();
        check("reflush_valid", {31'd0, fs_redirect_valid}, 1);
        check("reflush_pc", fs_redirect_pc, 32'h1C020000);
        fs_redirect_ready = 1;
        tick();
        idle_inputs();

        // PC wrap on refetch
        wb_refetch_flush = 1; wb_pc = 32'hFFFFFFFC;
        tick();
        idle_inputs(); fs_redirect_ready = 1;
        settle();
        check("wrap_pc", fs_redirect_pc, 32'h00000000);
        tick();
        idle_inputs();

        // Two requests in flight, then a flush: both responses dropped
        fs_req_fire = 1;
        tick(); tick();
        idle_inputs();
        settle();
        check("disc_outstanding2", {30'd0, outstanding}, 2);
        wb_ex = 1; csr_entry = 32'h1C030000;
        tick();
        idle_inputs(); fs_redirect_ready = 1;
        tick();
        idle_inputs(); fs_resp = 1;
        settle();
        check("disc_resp1", {31'd0, fs_resp_discard}, 1);
        tick();
        settle();
        check("disc_resp2", {31'd0, fs_resp_discard}, 1);
        tick();
        idle_inputs(); fs_req_fire = 1;
        settle();
        check("disc_outstanding0", {30'd0, outstanding}, 0);
        tick();
        idle_inputs(); fs_resp = 1;
        settle();
        check("disc_resp3_pass", {31'd0, fs_resp_discard}, 0);
        tick();
        idle_inputs();
        settle();
        check("disc_outstanding_end", {30'd0, outstanding}, 0);
        check("disc_proto_err", {31'd0, proto_err}, 0);

        // Flush coinciding with fire+resp at outstanding=1
        fs_req_fire = 1;
        tick();
        idle_inputs();
        wb_ex = 1; csr_entry = 32'h1C040000; fs_req_fire = 1; fs_resp = 1;
        settle();
        check("coinc_same_resp", {31'd0, fs_resp_discard}, 0);
        tick();
        idle_inputs();
        settle();
        check("coinc_outstanding", {30'd0, outstanding}, 1);
        fs_redirect_ready = 1;
        tick();
        idle_inputs(); fs_resp = 1;
        settle();
        check("coinc_discard", {31'd0, fs_resp_discard}, 1);
        tick();
        idle_inputs(); fs_req_fire = 1;
        tick();
        idle_inputs(); fs_resp = 1;
        settle();
        check("coinc_post_pass", {31'd0, fs_resp_discard}, 0);
        tick();
        idle_inputs();

        // Overflow: third request saturates the counter
        fs_req_fire = 1;
        tick(); tick(); tick();
        idle_inputs();
        settle();
        check("ovf_outstanding", {30'd0, outstanding}, 2);
        check("ovf_proto_err", {31'd0, proto_err}, 1);
        reset = 1;
        tick();
        reset = 0;
        settle();
        check("ovf_rst_proto_err", {31'd0, proto_err}, 0);

        // Underflow: response with nothing in flight
        fs_resp = 1;
        tick();
        idle_inputs();
        settle();
        check("unf_outstanding", {30'd0, outstanding}, 0);
        check("unf_proto_err", {31'd0, proto_err}, 1);
        tick(); tick();
        settle();
        check("unf_sticky", {31'd0, proto_err}, 1);

        // Reset asserted mid-REDIR
        wb_refetch_flush = 1; wb_pc = 32'h1C000200;
        tick();
        idle_inputs();
        settle();
        check("mid_valid", {31'd0, fs_redirect_valid}, 1);
        reset = 1; wb_refetch_flush = 1; fs_resp = 1;
        settle();
        check("inrst_valid", {31'd0, fs_redirect_valid}, 0);
        check("inrst_pc", fs_redirect_pc, 0);
        check("inrst_block", {31'd0, fs_req_block}, 0);
        check("inrst_discard", {31'd0, fs_resp_discard}, 0);
        tick();
        reset = 0;
        idle_inputs();
        settle();
        check("post_rst_valid", {31'd0, fs_redirect_valid}, 0);
        check("post_rst_pc", fs_redirect_pc, 0);
        check("post_rst_block", {31'd0, fs_req_block}, 0);
        check("post_rst_outstanding", {30'd0, outstanding}, 0);
        check("post_rst_proto_err", {31'd0, proto_err}, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
